// File: rtl/ins_encoder_loader.sv
// Packs MIPS instruction fields into 32-bit words and streams them through a small FIFO
// into instruction memory at sequential addresses. Optional error flag: INS_ENC_ERR_EN.
module ins_encoder_loader #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        fmt,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic [4:0]        sftamt,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       immd16,
    input  logic [25:0]       immd26,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   words_written,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       enc_word;
    logic [31:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              start_ok;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        enc_word = '0;
        case (fmt)
            2'd0:    enc_word = {op, rs, rt, rd, sftamt, func};
            2'd1:    enc_word = {op, rs, rt, immd16};
            2'd2:    enc_word = {op, immd26};
            default: enc_word = '0;
        endcase
    end

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign start_ok = (state == S_IDLE) && start;
    // Full blocks the input even when a pop happens in the same cycle.
    assign in_ready = (state == S_LOAD) && !full;
    assign push     = in_valid && in_ready;
    assign mem_we   = !empty && ((state == S_LOAD) || (state == S_FLUSH));
    assign pop      = mem_we && mem_ready;
    assign mem_wdata = mem_we ? fifo_mem[rd_ptr] : '0;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start)            state_next = S_LOAD;
            S_LOAD:  if (push && in_last)  state_next = S_FLUSH;
            S_FLUSH: if (empty)            state_next = S_DONE;
            S_DONE:                        state_next = S_IDLE;
            default:                       state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the storage array has no reset; the occupancy count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr      <= BASE;
            words_written <= '0;
        end else if (start_ok) begin
            mem_addr      <= BASE;
            words_written <= '0;
        end else if (pop) begin
            mem_addr      <= mem_addr + ADDR_W'(1);
            words_written <= words_written + (ADDR_W+1)'(1);
        end
    end

`ifdef INS_ENC_ERR_EN
    logic err_q;

    // Sticky: reserved format accepted, or a write at the top address (next address wraps).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if ((push && (fmt == 2'd3)) || (pop && (mem_addr == '1))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/ins_encoder_loader.md
Name: ins_encoder_loader

Overview:
- Inverse of the instruction-field decoder: accepts MIPS instruction fields over a valid/ready handshake.
- Packs each into a 32-bit instruction word per a format select.
- Buffers words in a small FIFO and streams them into instruction memory at sequential word addresses.
- Used by the testbench/boot path to load programs into the Tomasulo core's instruction memory before execution.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 8, instruction-memory word-address width
BASE_ADDR, 0, first word address written after start

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load session (ignored unless IDLE)
in_valid  in  1  field bundle valid
in_ready  out  1  block can accept a bundle this cycle
in_last  in  1  marks final instruction of session (qualified by in_valid&in_ready)
fmt  in  2  0=R, 1=I, 2=J, 3=reserved
op  in  6  opcode
func  in  6  R-format function
sftamt  in  5  shift amount
rs  in  5  source reg
rt  in  5  target reg
rd  in  5  dest reg
immd16  in  16  I-format immediate
immd26  in  26  J-format target
mem_we  out  1  write request to instruction memory
mem_ready  in  1  memory accepts write this cycle
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  encoded instruction
words_written  out  ADDR_W+1  writes completed this session
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when session complete
err  out  1  sticky error (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO empty, pointers 0, mem_addr=BASE_ADDR, words_written=0, in_ready=0, mem_we=0, mem_wdata=0, busy=0, done=0, err=0. Reset mid-session discards all buffered words; no further writes.
- Encoding (combinational at input, registered into FIFO):
  - R: {op,rs,rt,rd,sftamt,func}
  - I: {op,rs,rt,immd16}
  - J: {op,immd26}
  - fmt=3: 32'h0
  - Unused fields are ignored.
- FSM states:
  - IDLE --start--> LOAD. Also resets mem_addr=BASE_ADDR and words_written=0; err is cleared.
  - LOAD: in_ready = !full. On accept with in_last=1 -> FLUSH.
  - FLUSH: in_ready=0; when FIFO empty and no write pending -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - in_last accepted when FIFO already empty still passes through FLUSH: exactly one FLUSH cycle after the word is written.
- Push: in_valid & in_ready.
- Pop/write:
  - mem_we = !empty & (LOAD|FLUSH).
  - mem_wdata = FIFO head; mem_addr = current address.
  - Write completes on mem_we & mem_ready: pop, mem_addr+1, words_written+1.
  - While mem_ready=0, mem_we/addr/wdata hold stable.
- Latency: a bundle accepted in cycle N is presented on mem_we/mem_wdata no earlier than N+1 (registered FIFO, no bypass).
- Throughput: one accept and one write per cycle.
- Simultaneous push and pop: allowed when not full. When full, in_ready=0 even if a pop occurs that cycle.
- Pointer wrap: modulo DEPTH; full/empty distinguished by an occupancy count.
- mem_addr wraps modulo 2^ADDR_W.
- start while busy: ignored.

Optional Feature:
- Macro INS_ENC_ERR_EN.
- Defined: err sets (sticky until next accepted start or reset) on either of:
  - accepting a bundle with fmt=3 (the word is still encoded as 0 and written);
  - a write completing at mem_addr = 2^ADDR_W-1, i.e. the next address would wrap.
  - The session continues in both cases.
- Undefined: err tied 0; behaviour otherwise identical.

Test Plan:
- Reset, start, then one R bundle (op=0,rs=1,rt=2,rd=3,sftamt=0,func=6'h20) with in_last, mem_ready=1 -> one write, mem_addr=0, mem_wdata=32'h00221820; done pulses; words_written=1.
- I bundle (op=6'h23,rs=29,rt=8,immd16=16'hFFFC) and J bundle (op=2,immd26=26'h0000100), with junk in the unused fields -> words 32'h8FA8FFFC, 32'h08000100 at addresses 0 and 1.
- Hold mem_ready=0, push 5 bundles (DEPTH=4) -> in_ready drops after 4 accepts. mem_wdata/addr stay stable. Releasing mem_ready drains all 5 in order at addresses 0..4.
- Assert rst_n=0 with 3 words buffered and mem_ready=0 -> all outputs at reset values immediately, no further mem_we. After release, a new start writes from BASE_ADDR.
- Macro INS_ENC_ERR_EN defined, ADDR_W=2: write 5 words, one with fmt=3 -> err=1 after the fmt=3 accept; fourth write at address 3, fifth at address 0; that fmt=3 word written as 0. Macro undefined: same run leaves err=0.
- start pulsed during LOAD and FLUSH -> ignored; mem_addr continues sequentially, a single done pulse.
